hex_display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one segment bus. It latches a multi-digit hex value and steps through the digits. Each digit's nibble goes through a single HEXto7Segment decoder instance, and the controller drives one digit enable at a time with a blanking gap between digits to prevent ghosting. It sits between the cache-subsystem debug/status logic (the value source) and the board's segment/anode pins.

---
 rtl/hex_display_pkg.sv | 50 +++++
 rtl/hex_display_scan_ctrl_hex7seg.sv | 29 ++
 rtl/hex_display_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hex_display_scan_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment scan controller: blank code,
// scan state enum and the active-low 0-F segment patterns (bit6=g .. bit0=a).
package hex_display_pkg;

   typedef enum logic {
      ST_ON  = 1'b0,
      ST_GAP = 1'b1
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   function automatic logic [6:0] seg_of(input logic [3:0] nib);
      case (nib)
         4'h0: seg_of = SEG_0;
         4'h1: seg_of = SEG_1;
         4'h2: seg_of = SEG_2;
         4'h3: seg_of = SEG_3;
         4'h4: seg_of = SEG_4;
         4'h5: seg_of = SEG_5;
         4'h6: seg_of = SEG_6;
         4'h7: seg_of = SEG_7;
         4'h8: seg_of = SEG_8;
         4'h9: seg_of = SEG_9;
         4'hA: seg_of = SEG_A;
         4'hB: seg_of = SEG_B;
         4'hC: seg_of = SEG_C;
         4'hD: seg_of = SEG_D;
         4'hE: seg_of = SEG_E;
         default: seg_of = SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/hex_display_scan_ctrl_hex7seg.sv
// HEXto7Segment: combinational nibble to active-low seven-segment decoder
// (bit6=g .. bit0=a).
module HEXto7Segment (
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      case (i_hex)
         4'h0: o_seg = 7'b1000000;
         4'h1: o_seg = 7'b1111001;
         4'h2: o_seg = 7'b0100100;
         4'h3: o_seg = 7'b0110000;
         4'h4: o_seg = 7'b0011001;
         4'h5: o_seg = 7'b0010010;
         4'h6: o_seg = 7'b0000010;
         4'h7: o_seg = 7'b1111000;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0010000;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b0000011;
         4'hC: o_seg = 7'b1000110;
         4'hD: o_seg = 7'b0100001;
         4'hE: o_seg = 7'b0000110;
         default: o_seg = 7'b0001110;
      endcase
   end

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with frame-synchronous
// value commit. Optional macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module hex_display_scan_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic                      load,
   output logic [6:0]                seg_out,
   output logic [NUM_DIGITS-1:0]     digit_en,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                      frame_tick
);

   localparam int VW   = 4 * NUM_DIGITS;
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES - 1);

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [VW-1:0]         r_sh_val;
   logic [NUM_DIGITS-1:0] r_sh_mask;
   logic [VW-1:0]         r_act_val;
   logic [NUM_DIGITS-1:0] r_act_mask;
   logic                  r_pend;
   logic                  r_tick;
   logic                  r_armed;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_en;

   state_t                w_state_nxt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [IW-1:0]         w_idx_nxt;
   logic                  w_tick_nxt;
   logic [VW-1:0]         w_src_val;
   logic [NUM_DIGITS-1:0] w_src_mask;
   logic [VW-1:0]         w_act_val_nxt;
   logic [NUM_DIGITS-1:0] w_act_mask_nxt;
   logic [3:0]            w_nib;
   logic                  w_dark;
   logic [NUM_DIGITS-1:0] w_en_nxt;
   logic [6:0]            w_seg_dec;
   logic [6:0]            w_seg_nxt;

`ifdef LEADING_ZERO_BLANK_EN
   // Digit i goes dark when it and every digit above it are zero; digit 0 always shows.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VW-1:0]         v,
                                                     input logic [NUM_DIGITS-1:0] m);
      logic zero_above;
      lz_mask    = m;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (v[4*i +: 4] == 4'h0);
         if (zero_above) lz_mask[i] = 1'b1;
      end
   endfunction
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_ON: begin
            if (r_cnt == ON_LAST) begin
               w_state_nxt = ST_GAP;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = ST_ON;
               w_cnt_nxt   = '0;
               w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
         end
      endcase
      // The gap straight after reset has nothing to commit, so it is not a frame boundary.
      w_tick_nxt = r_armed && (w_state_nxt == ST_GAP) && (w_cnt_nxt == GAP_LAST) &&
                   (w_idx_nxt == LAST_IDX);
   end

   // A load on the commit cycle bypasses the shadow so it shows in the very next frame.
   always_comb begin
      w_src_val      = r_sh_val;
      w_src_mask     = r_sh_mask;
      w_act_val_nxt  = r_act_val;
      w_act_mask_nxt = r_act_mask;
      if (load) begin
         w_src_val  = value_in;
         w_src_mask = blank_mask;
      end
      if (r_tick && (load || r_pend)) begin
         w_act_val_nxt = w_src_val;
`ifdef LEADING_ZERO_BLANK_EN
         w_act_mask_nxt = lz_mask(w_src_val, w_src_mask);
`else
         w_act_mask_nxt = w_src_mask;
`endif
      end
   end

   always_comb begin
      w_nib    = '0;
      w_dark   = 1'b0;
      w_en_nxt = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_nxt == IW'(i)) begin
            w_nib  = w_act_val_nxt[4*i +: 4];
            w_dark = w_act_mask_nxt[i];
            if (w_state_nxt == ST_ON) w_en_nxt[i] = 1'b0;
         end
      end
   end

   HEXto7Segment u_hex7seg (
      .i_hex (w_nib),
      .o_seg (w_seg_dec)
   );

   assign w_seg_nxt = ((w_state_nxt == ST_ON) && !w_dark) ? w_seg_dec : SEG_BLANK;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_GAP;
         r_cnt      <= '0;
         r_idx      <= LAST_IDX;
         r_sh_val   <= '0;
         r_sh_mask  <= '0;
         r_act_val  <= '0;
         r_act_mask <= '0;
         r_pend     <= 1'b0;
         r_tick     <= 1'b0;
         r_armed    <= 1'b0;
         r_seg      <= SEG_BLANK;
         r_en       <= '1;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_act_val  <= w_act_val_nxt;
         r_act_mask <= w_act_mask_nxt;
         r_tick     <= w_tick_nxt;
         r_armed    <= r_armed | (w_state_nxt == ST_ON);
         r_seg      <= w_seg_nxt;
         r_en       <= w_en_nxt;
         if (load) begin
            r_sh_val  <= value_in;
            r_sh_mask <= blank_mask;
         end
         if (r_tick)    r_pend <= 1'b0;
         else if (load) r_pend <= 1'b1;
      end
   end

   assign seg_out    = r_seg;
   assign digit_en   = r_en;
   assign digit_idx  = r_idx;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Scoreboard bench for hex_display_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1).
// Expected outputs come from a frame-position model of the scan and commit rules.
module tb_hex_display_scan_ctrl;
   import hex_display_pkg::*;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int BC    = 1;
   localparam int SLOT  = RD + BC;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  blank_mask;
   logic [6:0]  seg_out;
   logic [3:0]  digit_en;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   always #5 clk = ~clk;

   hex_display_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value_in   (value_in),
      .blank_mask (blank_mask),
      .load       (load),
      .seg_out    (seg_out),
      .digit_en   (digit_en),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   typedef struct {
      logic [6:0] seg;
      logic [3:0] en;
      logic [1:0] idx;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // model state: position in frame of the cycle being driven, plus value registers
   int          m_p     = 0;
   bit          m_first = 1'b1;
   logic [15:0] m_act   = '0;
   logic [3:0]  m_act_m = '0;
   logic [15:0] m_sh    = '0;
   logic [3:0]  m_sh_m  = '0;
   bit          m_pend  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   function automatic logic [3:0] lz_bits(input logic [15:0] v);
      logic [3:0] b = 4'b0000;
      for (int i = 1; i < ND; i++)
         if ((v >> (4 * i)) == 16'h0000) b[i] = 1'b1;
      return b;
   endfunction
`endif

   function automatic exp_t expect_at(input int p);
      exp_t e;
      int   k = p / SLOT;
      int   r = p % SLOT;
      e.tick = (p == 0) && !m_first;
      if (r < BC) begin
         e.seg = SEG_BLANK;
         e.en  = 4'b1111;
         e.idx = 2'((k + ND - 1) % ND);
      end else begin
         e.en  = 4'b1111 & ~(4'b0001 << k);
         e.idx = 2'(k);
         e.seg = m_act_m[k] ? SEG_BLANK : seg_of(m_act[4*k +: 4]);
      end
      return e;
   endfunction

   task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] m);
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("seg_out", 32'(seg_out), 32'(e.seg));
         check("digit_en", 32'(digit_en), 32'(e.en));
         check("digit_idx", 32'(digit_idx), 32'(e.idx));
         check("frame_tick", 32'(frame_tick), 32'(e.tick));
      end
      rst        = r;
      load       = ld;
      value_in   = v;
      blank_mask = m;
      if (r) begin
         m_act = '0; m_act_m = '0; m_sh = '0; m_sh_m = '0;
         m_pend = 1'b0; m_p = 0; m_first = 1'b1;
      end else begin
         if (m_p == 0 && !m_first) begin
            if (ld) begin
               m_act = v; m_act_m = m;
`ifdef LEADING_ZERO_BLANK_EN
               m_act_m = m_act_m | lz_bits(v);
`endif
               m_pend = 1'b0;
            end else if (m_pend) begin
               m_act = m_sh; m_act_m = m_sh_m;
`ifdef LEADING_ZERO_BLANK_EN
               m_act_m = m_act_m | lz_bits(m_sh);
`endif
               m_pend = 1'b0;
            end
         end else if (ld) begin
            m_pend = 1'b1;
         end
         if (ld) begin
            m_sh = v; m_sh_m = m;
         end
         m_first = 1'b0;
         m_p     = (m_p + 1) % FRAME;
      end
      q.push_back(expect_at(m_p));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 4'h0);
   endtask

   task automatic wait_p(input int target);
      for (int i = 0; i < 2 * FRAME && !(m_p == target && !m_first); i++) idle(1);
      check("wait_pos", 32'(m_p), 32'(target));
   endtask

   task automatic load_at(input int p, input logic [15:0] v, input logic [3:0] m);
      wait_p(p);
      step(1'b0, 1'b1, v, m);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value_in = '0; blank_mask = '0;
      repeat (4) step(1'b1, 1'b0, 16'h0000, 4'h0);
      idle(3);
      load_at(3, 16'h12AF, 4'b0000);
      idle(2 * FRAME);
      load_at(7, 16'h3333, 4'b0000);      // digit 1 lit: rest of this frame unchanged
      idle(FRAME + 5);
      load_at(0, 16'h8888, 4'b0000);      // on the frame_tick cycle: bypass
      idle(FRAME);
      load_at(3, 16'h1111, 4'b0000);      // back-to-back, last one wins
      step(1'b0, 1'b1, 16'hABCD, 4'b0000);
      idle(2 * FRAME);
      load_at(2, 16'h5555, 4'b0100);
      idle(2 * FRAME);
      load_at(2, 16'h0050, 4'b0000);
      idle(2 * FRAME);
      wait_p(7);                          // reset during digit 1 ON phase
      step(1'b1, 1'b0, 16'h0000, 4'h0);
      idle(2 * FRAME);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
